// File: rtl/access_req_arbiter.sv
// -----------------------------------------------------------------------------
// access_req_arbiter
//
// Upstream request stage for the access-gated data register. Up to NUM_REQ
// requesters each offer a {user ID, data} write. One request per cycle is
// granted round-robin and queued in an in-order FIFO of DEPTH entries. The
// head entry is presented as a registered ID/data pair with valid/ready.
// IDs are passed through untouched; the downstream register does the check.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req_valid   per-requester request valid              [NUM_REQ]
//   req_id      requester i ID at [i*ID_W +: ID_W]
//   req_data    requester i data at [i*DATA_W +: DATA_W]
//   req_ready   one-hot grant, or all zero               [NUM_REQ]
//   out_valid   FIFO non-empty
//   out_usr_id  ID of the head entry
//   out_data    data of the head entry
//   out_ready   downstream accepts the head entry
//   fifo_count  current occupancy                        [$clog2(DEPTH)+1]
// -----------------------------------------------------------------------------
module access_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ID_W-1:0]     req_id,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [ID_W-1:0]             out_usr_id,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // (base + off) mod NUM_REQ; off is always below NUM_REQ here, so a single
  // conditional subtract suffices and NUM_REQ need not be a power of two.
  function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_W'(s);
  endfunction

  logic [RR_W-1:0]   rr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ID_W-1:0]   mem_id   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [ID_W-1:0]   id_arr   [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  logic [RR_W-1:0]   cand;
  logic [RR_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              push;
  logic              pop;

  // Unpack the flat request buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      id_arr[i]   = req_id[i*ID_W +: ID_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan starting at rr. A full FIFO grants nothing, even when
  // the head is popping this cycle. Grants are suppressed during reset since
  // the push would be discarded.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    req_ready = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (!rst && fifo_count < FULL_CNT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = wrap_add(rr, k);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign push = grant_vld;
  assign pop  = out_valid & out_ready;

  // Storage, pointers, round-robin pointer and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      // NOTE: the storage array is cleared on reset because the head entry
      // drives out_usr_id/out_data directly and must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_id[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (push) begin
        mem_id[wr_ptr]   <= id_arr[grant_idx];
        mem_data[wr_ptr] <= data_arr[grant_idx];
        wr_ptr           <= wr_ptr + PTR_W'(1);
        rr               <= wrap_add(grant_idx, 1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Outputs depend only on registered state.
  assign out_valid  = (fifo_count != '0);
  assign out_usr_id = mem_id[rd_ptr];
  assign out_data   = mem_data[rd_ptr];

endmodule

// File: tb/tb_access_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_access_req_arbiter
//
// Directed bench for access_req_arbiter (NUM_REQ=4, ID_W=3, DATA_W=8,
// DEPTH=4). Inputs change #1 after the rising edge; outputs are sampled
// before the next edge.
// -----------------------------------------------------------------------------
module tb_access_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ID_W-1:0]    req_id;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       out_valid;
  logic [ID_W-1:0]            out_usr_id;
  logic [DATA_W-1:0]          out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  access_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_usr_id (out_usr_id),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a single request from requester r; all others idle.
  task automatic drive_one(input int r, input logic [ID_W-1:0] id,
                           input logic [DATA_W-1:0] d);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_id[r*ID_W +: ID_W]       = id;
    req_data[r*DATA_W +: DATA_W] = d;
    #1;
  endtask

  // All requesters valid: requester i carries id=i, data=0x10+i.
  task automatic drive_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = 1'b1;
      req_id[i*ID_W +: ID_W]       = ID_W'(i);
      req_data[i*DATA_W +: DATA_W] = DATA_W'(8'h10 + i);
    end
    #1;
  endtask

  task automatic check_head(input string tag, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] d);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_id"},    32'(out_usr_id), 32'(id));
    check({tag, "_data"},  32'(out_data),   32'(d));
  endtask

  // Wrap-around scoreboard
  logic [ID_W+DATA_W-1:0] sb_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, rcvd, model_cnt, r;
    bit exp_grant, exp_pop;
    logic [ID_W+DATA_W-1:0] ent;

    rst = 1'b1; out_ready = 1'b0;
    req_valid = '0; req_id = '0; req_data = '0;
    tick(); tick();

    // ---------------- Reset state ----------------
    check("rst_valid", 32'(out_valid),  32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_id",    32'(out_usr_id), 32'd0);
    check("rst_data",  32'(out_data),   32'd0);
    check("rst_ready", 32'(req_ready),  32'd0);
    rst = 1'b0;

    // ---------------- Single request ----------------
    out_ready = 1'b1;
    drive_one(2, 3'd4, 8'hA5);
    check("single_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0; #1;
    check("single_ready_off", 32'(req_ready), 32'd0);
    check_head("single", 3'd4, 8'hA5);
    check("single_count", 32'(fifo_count), 32'd1);
    tick();
    check("single_empty", 32'(out_valid), 32'd0);
    check("single_count0", 32'(fifo_count), 32'd0);
    // rr is now 3

    // ---------------- Fill / full ----------------
    out_ready = 1'b0;
    drive_all();
    check("fill_g0", 32'(req_ready), 32'b1000); tick();
    check("fill_g1", 32'(req_ready), 32'b0001); tick();
    check("fill_g2", 32'(req_ready), 32'b0010); tick();
    check("fill_g3", 32'(req_ready), 32'b0100); tick();
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(req_ready),  32'd0);
    check_head("full_head", 3'd3, 8'h13);
    out_ready = 1'b1; #1;
    check("full_pop_nobypass", 32'(req_ready), 32'd0);
    tick();
    out_ready = 1'b0; #1;
    check("after_pop_count", 32'(fifo_count), 32'd3);
    check_head("after_pop_head", 3'd0, 8'h10);
    check("refill_grant", 32'(req_ready), 32'b1000);
    tick();
    check("refill_count", 32'(fifo_count), 32'd4);
    check("refill_ready", 32'(req_ready),  32'd0);
    // FIFO: id0, id1, id2, id3; rr = 0

    // ---------------- Mid-cycle reset with 3 queued ----------------
    req_valid = '0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    drive_one(1, 3'd1, 8'h11);
    check("pre_rst_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0; #1;
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    check_head("pre_rst_head", 3'd2, 8'h12);
    #1 rst = 1'b1;   // clock is still high: well away from any edge
    #1;
    check("mid_rst_valid", 32'(out_valid),  32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_id",    32'(out_usr_id), 32'd0);
    check("mid_rst_data",  32'(out_data),   32'd0);
    tick();
    rst = 1'b0;

    // ---------------- Round-robin, out_ready=1 ----------------
    out_ready = 1'b1;
    drive_all();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check_head($sformatf("rr_out%0d", k), ID_W'(k % 4), DATA_W'(8'h10 + k % 4));
      check($sformatf("rr_count%0d", k), 32'(fifo_count), 32'd1);
    end
    req_valid = '0;
    tick();
    check("rr_drained", 32'(fifo_count), 32'd0);

    // ---------------- Wrap-around with scoreboard ----------------
    sent = 0; rcvd = 0; model_cnt = 0;
    for (int cyc = 0; cyc < 200 && (rcvd < 20); cyc++) begin
      out_ready = cyc[0];
      if (sent < 20) begin
        r = (sent % 2 == 0) ? 1 : 3;
        drive_one(r, ID_W'(sent % 8), DATA_W'(8'h40 + sent));
      end else begin
        req_valid = '0; #1;
      end
      exp_grant = (sent < 20) && (model_cnt < DEPTH);
      exp_pop   = (model_cnt != 0) && out_ready;
      check("wrap_grant", 32'(req_ready), exp_grant ? 32'(1 << r) : 32'd0);
      check("wrap_count", 32'(fifo_count), 32'(model_cnt));
      check("wrap_valid", 32'(out_valid), 32'(model_cnt != 0));
      if (model_cnt != 0) begin
        check("wrap_head", 32'({out_usr_id, out_data}), 32'(sb_q[0]));
      end
      if (exp_pop) begin
        ent = sb_q.pop_front();
        rcvd++;
        model_cnt--;
      end
      if (exp_grant) begin
        sb_q.push_back({ID_W'(sent % 8), DATA_W'(8'h40 + sent)});
        sent++;
        model_cnt++;
      end
      tick();
    end
    check("wrap_all_received", 32'(rcvd), 32'd20);
    check("wrap_end_count", 32'(fifo_count), 32'd0);
    req_valid = '0; out_ready = 1'b0;

    // ---------------- Simultaneous push/pop ----------------
    drive_one(0, 3'd5, 8'h55);
    check("pp_grantA", 32'(req_ready), 32'b0001);
    tick();
    drive_one(2, 3'd6, 8'h66);
    check("pp_grantB", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0; #1;
    check("pp_count2", 32'(fifo_count), 32'd2);
    check_head("pp_head0", 3'd5, 8'h55);
    out_ready = 1'b1;
    drive_one(1, 3'd7, 8'h77);
    check("pp_grantC", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0; #1;
    check("pp_count_same", 32'(fifo_count), 32'd2);
    check_head("pp_head1", 3'd6, 8'h66);
    tick();
    check_head("pp_head2", 3'd7, 8'h77);
    tick();
    check("pp_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
